in_fft_pair_buffer: RTL and testbench
=====================================

# in_fft_pair_buffer

Input-side frame buffer for the iterative radix-2 DIF FFT core. It accepts one complex sample per cycle in natural order until a full N = 2^AWL frame is stored. It then hands the frame to the butterfly engine as complex pairs (x[k], x[k+N/2]), k = 0..N/2-1, one pair per accepted read, for the first stage. It is the write-serial / read-dual counterpart of the output FIFO on the FFT result side.

## Interface
- DWL, 16, data word length of each real/imag component
- AWL, 8, log2 of frame length N; each bank is N/2 deep
- WR_CLK  in  1  single clock for all logic
- R_RST  in  1  reset; synchronous, active-high, sampled on WR_CLK
- WR_INC  in  1  write strobe; accepted when WR_INC & !WR_FULL
- WR_DATA_R  in  DWL  sample real part
- WR_DATA_I  in  DWL  sample imag part
- WR_FULL  out  1  frame stored, writes refused
- R_INC  in  1  pair read strobe; accepted when R_INC & !R_EMPTY
- R_DATA_1_R / R_DATA_1_I  out  DWL  x[k]
- R_DATA_2_R / R_DATA_2_I  out  DWL  x[k+N/2]
- R_K  out  AWL-1  pair index k of the current R_DATA
- R_VALID  out  1  one-cycle pulse; R_DATA/R_K updated this cycle
- R_EMPTY  out  1  no unread pair available
- FRAME_RDY  out  1  one-cycle pulse when a frame completes

## Operation
- Storage: two N/2-deep banks, each holding real and imag. Bank LO holds indices 0..N/2-1; bank HI holds N/2..N-1. Bank select is wr_cnt[AWL-1]; bank address is wr_cnt[AWL-2:0].
- Counters: wr_cnt (AWL bits) and rd_cnt (AWL-1 bits), both reset to 0.
- FSM states: FILL (reset state), FULL, DRAIN.
- FILL:
  - Accepted write stores the sample at wr_cnt and increments wr_cnt.
  - The accepted write at wr_cnt = N-1 wraps wr_cnt to 0 and moves to FULL.
  - R_INC is ignored.
- FULL:
  - WR_INC is ignored; memory is unchanged.
  - An accepted R_INC reads LO[rd_cnt] and HI[rd_cnt] in the same cycle, increments rd_cnt, and moves to DRAIN.
  - If that accept is also the last pair (N/2 = 1, i.e. AWL = 1), go directly to FILL.
- DRAIN:
  - Each accepted read behaves as in FULL.
  - The accept at rd_cnt = N/2-1 wraps rd_cnt to 0 and moves to FILL.
  - Writes are ignored until the state is FILL.
- Flags: WR_FULL = (state != FILL) and R_EMPTY = (state == FILL). Both are decoded from the registered state.
- Simultaneous WR_INC and R_INC: only the strobe legal in the current state has effect.
- Reset mid-frame, asserted in any state:
  - State goes to FILL and both counters to 0.
  - Partial frame is discarded; memory contents are not cleared.
- Reset values:
  - WR_FULL = 0, R_EMPTY = 1.
  - R_VALID = 0, FRAME_RDY = 0.
  - R_DATA_* = 0, R_K = 0.

## Timing
- Write path:
  - Write accepted at edge t: the sample is readable from edge t+1.
  - The Nth accepted write at edge t makes WR_FULL = 1, R_EMPTY = 0 and FRAME_RDY = 1 during cycle t+1.
  - FRAME_RDY is high for that cycle only.
- Read latency is 1 cycle. For a read accepted at edge t, during cycle t+1:
  - R_DATA_1/2 and R_K hold the pair.
  - R_VALID = 1.
- R_DATA and R_K hold their value until the next accepted read.
- A back-to-back R_INC gives one pair per cycle with no bubbles.
- Last pair accepted at edge t:
  - R_EMPTY = 1 and WR_FULL = 0 during cycle t+1.
  - A write in cycle t+1 is accepted and goes to index 0.
  - R_DATA is registered, so the new write cannot corrupt the pair being presented.
- Full-frame throughput: N write cycles + N/2 read cycles; no dead cycles are mandated between phases.

## Test plan
- AWL=3, DWL=16, reset:
  - Stimulus: write 8 samples, sample n = (re n, im 100+n), WR_INC held high.
  - Required: FRAME_RDY pulses once, in the cycle after the 8th write; WR_FULL = 1 and R_EMPTY = 0 in that same cycle.
- Continue with R_INC held high for 4 cycles:
  - Required: R_VALID high for 4 cycles.
  - Pairs (k, x1, x2) are (0, 0, 4), (1, 1, 5), (2, 2, 6), (3, 3, 7); imag parts offset by 100.
  - R_EMPTY = 1 after the last pair.
- Writes while full:
  - Stimulus: in FULL, drive 3 writes of 0xDEAD, then drain.
  - Required: pairs unchanged from the previous test; WR_FULL stays 1 until the drain completes.
- Early read and throttled read:
  - Stimulus: assert R_INC during FILL after 5 writes.
  - Required: no R_VALID; rd_cnt stays 0.
  - Then complete the frame and drain with R_INC alternating 1/0. Required: 4 pairs correct, each R_DATA held through the idle cycles.
- Reset mid-drain:
  - Stimulus: assert R_RST after 2 pairs are read.
  - Required: next cycle WR_FULL = 0, R_EMPTY = 1, R_DATA = 0.
  - A new 8-sample frame then reads back from k = 0.
- Overlap at the phase boundary:
  - Stimulus: a write is held pending (WR_INC = 1) across the last read.
  - Required: the write is accepted in the cycle after the last read, at index 0.
  - The last presented pair (3, 3, 7) is intact.

Source files
------------

// File: rtl/in_fft_pair_buffer.sv
// Input frame buffer for the radix-2 DIF FFT: serial natural-order writes,
// then first-stage butterfly pairs (x[k], x[k+N/2]) read out one pair per accept.
module in_fft_pair_buffer #(
   parameter int DWL = 16,
   parameter int AWL = 8
) (
   input  logic           WR_CLK,
   input  logic           R_RST,
   input  logic           WR_INC,
   input  logic [DWL-1:0] WR_DATA_R,
   input  logic [DWL-1:0] WR_DATA_I,
   output logic           WR_FULL,
   input  logic           R_INC,
   output logic [DWL-1:0] R_DATA_1_R,
   output logic [DWL-1:0] R_DATA_1_I,
   output logic [DWL-1:0] R_DATA_2_R,
   output logic [DWL-1:0] R_DATA_2_I,
   output logic [AWL-2:0] R_K,
   output logic           R_VALID,
   output logic           R_EMPTY,
   output logic           FRAME_RDY
);

   localparam int HALF = 1 << (AWL - 1);
   localparam logic [AWL-1:0] WR_ONE = 1;
   localparam logic [AWL-2:0] RD_ONE = 1;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [AWL-1:0] wr_cnt_q, wr_cnt_d;
   logic [AWL-2:0] rd_cnt_q, rd_cnt_d;

   logic [DWL-1:0] d1_r_q, d1_r_d;
   logic [DWL-1:0] d1_i_q, d1_i_d;
   logic [DWL-1:0] d2_r_q, d2_r_d;
   logic [DWL-1:0] d2_i_q, d2_i_d;
   logic [AWL-2:0] k_q, k_d;
   logic           valid_q, valid_d;
   logic           frame_rdy_q, frame_rdy_d;

   // Bank LO holds x[0..N/2-1], bank HI holds x[N/2..N-1]
   logic [DWL-1:0] lo_mem_r [HALF];
   logic [DWL-1:0] lo_mem_i [HALF];
   logic [DWL-1:0] hi_mem_r [HALF];
   logic [DWL-1:0] hi_mem_i [HALF];

   logic wr_acc;
   logic rd_acc;

   assign wr_acc = WR_INC && (state_q == FILL);
   assign rd_acc = R_INC && (state_q != FILL);

   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      d1_r_d      = d1_r_q;
      d1_i_d      = d1_i_q;
      d2_r_d      = d2_r_q;
      d2_i_d      = d2_i_q;
      k_d         = k_q;
      valid_d     = 1'b0;
      frame_rdy_d = 1'b0;
      case (state_q)
         FILL: begin
            if (wr_acc) begin
               wr_cnt_d = wr_cnt_q + WR_ONE;
               if (wr_cnt_q == '1) begin
                  state_d     = FULL;
                  frame_rdy_d = 1'b1;
               end
            end
         end
         FULL, DRAIN: begin
            if (rd_acc) begin
               rd_cnt_d = rd_cnt_q + RD_ONE;
               d1_r_d   = lo_mem_r[rd_cnt_q];
               d1_i_d   = lo_mem_i[rd_cnt_q];
               d2_r_d   = hi_mem_r[rd_cnt_q];
               d2_i_d   = hi_mem_i[rd_cnt_q];
               k_d      = rd_cnt_q;
               valid_d  = 1'b1;
               state_d  = (rd_cnt_q == '1) ? FILL : DRAIN;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Storage is deliberately not reset; a reset only discards the frame bookkeeping
   always_ff @(posedge WR_CLK) begin
      if (wr_acc && !R_RST) begin
         if (wr_cnt_q[AWL-1]) begin
            hi_mem_r[wr_cnt_q[AWL-2:0]] <= WR_DATA_R;
            hi_mem_i[wr_cnt_q[AWL-2:0]] <= WR_DATA_I;
         end else begin
            lo_mem_r[wr_cnt_q[AWL-2:0]] <= WR_DATA_R;
            lo_mem_i[wr_cnt_q[AWL-2:0]] <= WR_DATA_I;
         end
      end
   end

   always_ff @(posedge WR_CLK) begin
      if (R_RST) begin
         state_q     <= FILL;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         d1_r_q      <= '0;
         d1_i_q      <= '0;
         d2_r_q      <= '0;
         d2_i_q      <= '0;
         k_q         <= '0;
         valid_q     <= 1'b0;
         frame_rdy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         d1_r_q      <= d1_r_d;
         d1_i_q      <= d1_i_d;
         d2_r_q      <= d2_r_d;
         d2_i_q      <= d2_i_d;
         k_q         <= k_d;
         valid_q     <= valid_d;
         frame_rdy_q <= frame_rdy_d;
      end
   end

   assign WR_FULL    = (state_q != FILL);
   assign R_EMPTY    = (state_q == FILL);
   assign R_DATA_1_R = d1_r_q;
   assign R_DATA_1_I = d1_i_q;
   assign R_DATA_2_R = d2_r_q;
   assign R_DATA_2_I = d2_i_q;
   assign R_K        = k_q;
   assign R_VALID    = valid_q;
   assign FRAME_RDY  = frame_rdy_q;

endmodule

// File: tb/tb_in_fft_pair_buffer.sv
// Self-checking bench for in_fft_pair_buffer (N = 8): frame-level reference
// model compared every cycle, plus literal checks of the directed scenarios.
module tb_in_fft_pair_buffer;

   localparam int DWL = 16;
   localparam int AWL = 3;
   localparam int N   = 1 << AWL;
   localparam int H   = N / 2;

   logic           wr_clk = 1'b0;
   logic           r_rst  = 1'b1;
   logic           wr_inc = 1'b0;
   logic [DWL-1:0] wr_data_r = '0;
   logic [DWL-1:0] wr_data_i = '0;
   logic           wr_full;
   logic           r_inc = 1'b0;
   logic [DWL-1:0] r_data_1_r, r_data_1_i, r_data_2_r, r_data_2_i;
   logic [AWL-2:0] r_k;
   logic           r_valid, r_empty, frame_rdy;

   int checks = 0;
   int errors = 0;

   in_fft_pair_buffer #(.DWL(DWL), .AWL(AWL)) dut (
      .WR_CLK(wr_clk), .R_RST(r_rst), .WR_INC(wr_inc),
      .WR_DATA_R(wr_data_r), .WR_DATA_I(wr_data_i), .WR_FULL(wr_full),
      .R_INC(r_inc), .R_DATA_1_R(r_data_1_r), .R_DATA_1_I(r_data_1_i),
      .R_DATA_2_R(r_data_2_r), .R_DATA_2_I(r_data_2_i), .R_K(r_k),
      .R_VALID(r_valid), .R_EMPTY(r_empty), .FRAME_RDY(frame_rdy)
   );

   always #5 wr_clk = ~wr_clk;

   // Reference model: a frame is "stored" samples long; once all N are in,
   // pairs are handed out until N/2 have gone, then a new frame may start.
   logic [DWL-1:0] mdl_re [N];
   logic [DWL-1:0] mdl_im [N];
   int             stored = 0;
   int             pairs  = 0;
   bit             mdl_live = 1'b0;
   logic [DWL-1:0] exp_d1r = '0, exp_d1i = '0, exp_d2r = '0, exp_d2i = '0;
   int             exp_k = 0;
   bit             exp_valid = 1'b0, exp_frdy = 1'b0;

   always @(posedge wr_clk) begin
      if (r_rst) begin
         stored = 0; pairs = 0; mdl_live = 1'b1;
         exp_d1r = '0; exp_d1i = '0; exp_d2r = '0; exp_d2i = '0;
         exp_k = 0; exp_valid = 1'b0; exp_frdy = 1'b0;
      end else begin
         exp_valid = 1'b0;
         exp_frdy  = 1'b0;
         if (stored == N) begin
            if (r_inc) begin
               exp_k     = pairs;
               exp_d1r   = mdl_re[pairs];
               exp_d1i   = mdl_im[pairs];
               exp_d2r   = mdl_re[pairs + H];
               exp_d2i   = mdl_im[pairs + H];
               exp_valid = 1'b1;
               pairs     = pairs + 1;
               if (pairs == H) begin
                  stored = 0;
                  pairs  = 0;
               end
            end
         end else if (wr_inc) begin
            mdl_re[stored] = wr_data_r;
            mdl_im[stored] = wr_data_i;
            stored = stored + 1;
            if (stored == N) exp_frdy = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, got, got, exp, exp, $time);
      end
   endtask

   always @(negedge wr_clk) begin
      if (mdl_live) begin
         checkOutput("mdl_wr_full",   int'(wr_full),   int'(stored == N));
         checkOutput("mdl_r_empty",   int'(r_empty),   int'(stored != N));
         checkOutput("mdl_r_valid",   int'(r_valid),   int'(exp_valid));
         checkOutput("mdl_frame_rdy", int'(frame_rdy), int'(exp_frdy));
         checkOutput("mdl_r_k",       int'(r_k),       exp_k);
         checkOutput("mdl_d1_r",      int'(r_data_1_r), int'(exp_d1r));
         checkOutput("mdl_d1_i",      int'(r_data_1_i), int'(exp_d1i));
         checkOutput("mdl_d2_r",      int'(r_data_2_r), int'(exp_d2r));
         checkOutput("mdl_d2_i",      int'(r_data_2_i), int'(exp_d2i));
      end
   end

   // Inputs are held across one rising edge; returns at the following falling edge
   task automatic applyStimulus(input bit wr, input int dr, input int di, input bit rd);
      wr_inc    = wr;
      wr_data_r = DWL'(dr);
      wr_data_i = DWL'(di);
      r_inc     = rd;
      @(negedge wr_clk);
   endtask

   task automatic checkPair(input string tag, input int k, input int x1r, input int x1i,
                            input int x2r, input int x2i);
      checkOutput({tag, "_k"},  int'(r_k),        k);
      checkOutput({tag, "_1r"}, int'(r_data_1_r), x1r);
      checkOutput({tag, "_1i"}, int'(r_data_1_i), x1i);
      checkOutput({tag, "_2r"}, int'(r_data_2_r), x2r);
      checkOutput({tag, "_2i"}, int'(r_data_2_i), x2i);
   endtask

   task automatic writeRamp(input int base);
      for (int n = 0; n < N; n++) applyStimulus(1'b1, base + n, 100 + base + n, 1'b0);
   endtask

   initial begin
      r_rst = 1'b1;
      @(negedge wr_clk);
      @(negedge wr_clk);
      checkOutput("rst_wr_full", int'(wr_full), 0);
      checkOutput("rst_r_empty", int'(r_empty), 1);
      checkOutput("rst_r_valid", int'(r_valid), 0);
      checkOutput("rst_frame_rdy", int'(frame_rdy), 0);
      checkPair("rst", 0, 0, 0, 0, 0);
      r_rst = 1'b0;

      // Frame fill and first drain
      for (int n = 0; n < N; n++) begin
         applyStimulus(1'b1, n, 100 + n, 1'b0);
         if (n == N - 2) checkOutput("t1_frdy_early", int'(frame_rdy), 0);
      end
      checkOutput("t1_frame_rdy", int'(frame_rdy), 1);
      checkOutput("t1_wr_full", int'(wr_full), 1);
      checkOutput("t1_r_empty", int'(r_empty), 0);
      for (int k = 0; k < H; k++) begin
         applyStimulus(1'b0, 0, 0, 1'b1);
         checkOutput("t2_valid", int'(r_valid), 1);
         checkPair("t2_pair", k, k, 100 + k, k + 4, 104 + k);
      end
      checkOutput("t2_empty_end", int'(r_empty), 1);
      applyStimulus(1'b0, 0, 0, 1'b0);
      checkOutput("t2_valid_drop", int'(r_valid), 0);

      // Writes while full are refused
      writeRamp(0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 16'hDEAD, 16'hDEAD, 1'b0);
         checkOutput("t3_wr_full", int'(wr_full), 1);
      end
      for (int k = 0; k < H; k++) begin
         applyStimulus(1'b0, 0, 0, 1'b1);
         checkPair("t3_pair", k, k, 100 + k, k + 4, 104 + k);
         if (k < H - 1) checkOutput("t3_full_hold", int'(wr_full), 1);
      end
      checkOutput("t3_full_drop", int'(wr_full), 0);

      // Early read during FILL, then throttled drain
      for (int n = 0; n < 5; n++) applyStimulus(1'b1, 20 + n, 120 + n, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1);
      checkOutput("t4_early_valid", int'(r_valid), 0);
      applyStimulus(1'b0, 0, 0, 1'b1);
      checkOutput("t4_early_valid2", int'(r_valid), 0);
      for (int n = 5; n < N; n++) applyStimulus(1'b1, 20 + n, 120 + n, 1'b0);
      for (int k = 0; k < H; k++) begin
         applyStimulus(1'b0, 0, 0, 1'b1);
         checkPair("t4_pair", k, 20 + k, 120 + k, 24 + k, 124 + k);
         applyStimulus(1'b0, 0, 0, 1'b0);
         checkOutput("t4_idle_valid", int'(r_valid), 0);
         checkPair("t4_hold", k, 20 + k, 120 + k, 24 + k, 124 + k);
      end

      // Reset mid-drain, then a fresh random frame reads back from k = 0
      for (int n = 0; n < N; n++) applyStimulus(1'b1, $urandom, $urandom, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b1);
      r_rst = 1'b1;
      applyStimulus(1'b0, 0, 0, 1'b0);
      r_rst = 1'b0;
      checkOutput("t5_wr_full", int'(wr_full), 0);
      checkOutput("t5_r_empty", int'(r_empty), 1);
      checkPair("t5_cleared", 0, 0, 0, 0, 0);
      for (int n = 0; n < N; n++) applyStimulus(1'b1, $urandom, $urandom, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1);
      checkOutput("t5_first_k", int'(r_k), 0);
      for (int k = 1; k < H; k++) applyStimulus(1'b0, 0, 0, 1'b1);

      // Write held pending across the last read
      writeRamp(0);
      for (int k = 0; k < H - 1; k++) applyStimulus(1'b0, 0, 0, 1'b1);
      applyStimulus(1'b1, 16'h55, 16'h66, 1'b1);
      checkPair("t6_last", 3, 3, 103, 7, 107);
      checkOutput("t6_empty", int'(r_empty), 1);
      applyStimulus(1'b1, 16'h55, 16'h66, 1'b0);
      checkPair("t6_intact", 3, 3, 103, 7, 107);
      for (int n = 1; n < N; n++) applyStimulus(1'b1, n, 100 + n, 1'b0);
      checkOutput("t6_frame_rdy", int'(frame_rdy), 1);
      applyStimulus(1'b0, 0, 0, 1'b1);
      checkPair("t6_idx0", 0, 16'h55, 16'h66, 4, 104);
      for (int k = 1; k < H; k++) applyStimulus(1'b0, 0, 0, 1'b1);

      // Random soak with occasional resets
      for (int c = 0; c < 600; c++) begin
         r_rst = ($urandom_range(0, 79) == 0);
         applyStimulus(1'(($urandom_range(0, 3)) != 0), $urandom, $urandom,
                       1'($urandom_range(0, 1)));
      end
      r_rst = 1'b0;
      applyStimulus(1'b0, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
